// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: conditions the raw clock/data pins, deserialises 11-bit
// frames and folds E0/F0 prefixes into single make/break scan-code events.
module ps2_keyboard #(
    parameter int FILTER  = 16,
    parameter int TIMEOUT = 56000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2Ck,
    input  logic       ps2D,
    output logic       kstb,
    output logic       make,
    output logic [7:0] code,
    output logic       ext,
    output logic       err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    localparam logic [6:0]  FILT_LAST = 7'(FILTER - 1);
    localparam logic [15:0] TO_LIMIT  = 16'(TIMEOUT);

    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic        ck_meta_r, ck_sync_r, d_meta_r, d_sync_r;
    logic        fck_r, fall_r, bit_r;
    logic [6:0]  filt_cnt_r;
    logic [15:0] to_cnt_r;
    state_t      state_r, state_nx_s;
    logic [7:0]  sr_r, sr_nx_s;
    logic [2:0]  bit_cnt_r, bit_cnt_nx_s;
    logic        par_ok_r, par_ok_nx_s;
    logic        accept_s, bad_s, timeout_s;
    logic        brk_r, extf_r;
    logic        kstb_r, make_r, ext_r, err_r;
    logic [7:0]  code_r;

    assign kstb = kstb_r;
    assign make = make_r;
    assign code = code_r;
    assign ext  = ext_r;
    assign err  = err_r;

    // Two-flop synchronisers; idle PS/2 lines are high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ck_meta_r <= 1'b1;
            ck_sync_r <= 1'b1;
            d_meta_r  <= 1'b1;
            d_sync_r  <= 1'b1;
        end else begin
            ck_meta_r <= ps2Ck;
            ck_sync_r <= ck_meta_r;
            d_meta_r  <= ps2D;
            d_sync_r  <= d_meta_r;
        end
    end

    // Clock de-glitch filter; the data bit is captured with the filtered falling edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fck_r      <= 1'b1;
            filt_cnt_r <= 7'd0;
            fall_r     <= 1'b0;
            bit_r      <= 1'b1;
        end else if (ck_sync_r == fck_r) begin
            filt_cnt_r <= 7'd0;
            fall_r     <= 1'b0;
        end else if (filt_cnt_r == FILT_LAST) begin
            fck_r      <= ~fck_r;
            filt_cnt_r <= 7'd0;
            fall_r     <= fck_r;
            bit_r      <= d_sync_r;
        end else begin
            filt_cnt_r <= filt_cnt_r + 7'd1;
            fall_r     <= 1'b0;
        end
    end

    // Frame timeout counter, restarted by every filtered falling edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt_r <= 16'd0;
        end else if (state_r == ST_IDLE || fall_r) begin
            to_cnt_r <= 16'd0;
        end else begin
            to_cnt_r <= to_cnt_r + 16'd1;
        end
    end

    assign timeout_s = (state_r != ST_IDLE) && (to_cnt_r == TO_LIMIT);

    // Frame FSM next-state; a timeout overrides any coincident falling edge.
    always_comb begin
        state_nx_s   = state_r;
        sr_nx_s      = sr_r;
        bit_cnt_nx_s = bit_cnt_r;
        par_ok_nx_s  = par_ok_r;
        accept_s     = 1'b0;
        bad_s        = 1'b0;
        if (timeout_s) begin
            state_nx_s = ST_IDLE;
        end else if (fall_r) begin
            case (state_r)
                ST_IDLE: begin
                    if (!bit_r) begin
                        state_nx_s   = ST_DATA;
                        bit_cnt_nx_s = 3'd0;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    sr_nx_s      = {bit_r, sr_r[7:1]};
                    bit_cnt_nx_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        state_nx_s = ST_PARITY;
                    end else begin
                        state_nx_s = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    par_ok_nx_s = parity_ok(sr_r, bit_r);
                    state_nx_s  = ST_STOP;
                end
                ST_STOP: begin
                    if (bit_r && par_ok_r) begin
                        accept_s = 1'b1;
                    end else begin
                        bad_s = 1'b1;
                    end
                    state_nx_s = ST_IDLE;
                end
                default: state_nx_s = ST_IDLE;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Frame FSM state and shift register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            sr_r      <= 8'h00;
            bit_cnt_r <= 3'd0;
            par_ok_r  <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            sr_r      <= sr_nx_s;
            bit_cnt_r <= bit_cnt_nx_s;
            par_ok_r  <= par_ok_nx_s;
        end
    end

    // Prefix tracking and event outputs; any failed frame drops pending prefixes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            kstb_r <= 1'b0;
            err_r  <= 1'b0;
            make_r <= 1'b0;
            ext_r  <= 1'b0;
            code_r <= 8'h00;
            brk_r  <= 1'b0;
            extf_r <= 1'b0;
        end else begin
            kstb_r <= 1'b0;
            err_r  <= 1'b0;
            if (timeout_s || bad_s) begin
                err_r  <= 1'b1;
                brk_r  <= 1'b0;
                extf_r <= 1'b0;
            end else if (accept_s) begin
                case (sr_r)
                    8'hF0: brk_r  <= 1'b1;
                    8'hE0: extf_r <= 1'b1;
                    default: begin
                        kstb_r <= 1'b1;
                        code_r <= sr_r;
                        make_r <= ~brk_r;
                        ext_r  <= extf_r;
                        brk_r  <= 1'b0;
                        extf_r <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Scoreboard bench for ps2_keyboard: directed PS/2 frames push expected events,
// a negedge monitor pops and compares whenever kstb or err fires.
module tb_ps2_keyboard;

    localparam int FILT = 16;
    localparam int TOUT = 2000;
    localparam int HALF = 40;

    typedef struct packed {
        logic       is_err;
        logic [7:0] code;
        logic       make;
        logic       ext;
    } ev_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2Ck;
    logic       ps2D;
    logic       kstb, make, ext, err;
    logic [7:0] code;

    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  last_fall_cyc = 0;
    int  err_cyc = 0;
    int  delta;
    ev_t exp_q[$];
    ev_t mon_e;

    ps2_keyboard #(.FILTER(FILT), .TIMEOUT(TOUT)) dut (
        .clock(clock), .reset(reset), .ps2Ck(ps2Ck), .ps2D(ps2D),
        .kstb(kstb), .make(make), .code(code), .ext(ext), .err(err)
    );

    always #9 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic p;
        p = ~(^b) ^ bad_par;
        return {~bad_stop, p, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2D = bits[i];
            wait_clk(HALF);
            ps2Ck = 1'b0;
            last_fall_cyc = cyc;
            wait_clk(HALF);
            ps2Ck = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bp = 1'b0, input logic bs = 1'b0);
        send_bits(frame(b, bp, bs), 11);
        ps2D = 1'b1;
        wait_clk(4 * HALF);
    endtask

    task automatic push_key(input logic [7:0] c, input logic m, input logic x);
        ev_t e;
        e.is_err = 1'b0;
        e.code   = c;
        e.make   = m;
        e.ext    = x;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        ev_t e;
        e = '0;
        e.is_err = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_kstb"}, {31'd0, kstb}, 32'd0);
        check({tag, "_err"},  {31'd0, err},  32'd0);
        check({tag, "_make"}, {31'd0, make}, 32'd0);
        check({tag, "_ext"},  {31'd0, ext},  32'd0);
        check({tag, "_code"}, {24'd0, code}, 32'h00);
    endtask

    // Monitor: every strobe or error pulse must match the head of the queue.
    always @(negedge clock) begin
        if (reset === 1'b1 && (kstb === 1'b1 || err === 1'b1)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got kstb=%b err=%b code=%h, required no event", kstb, err, code);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_err", {31'd0, err}, {31'd0, mon_e.is_err});
                check("event_kstb", {31'd0, kstb}, {31'd0, ~mon_e.is_err});
                if (!mon_e.is_err) begin
                    check("event_code", {24'd0, code}, {24'd0, mon_e.code});
                    check("event_make", {31'd0, make}, {31'd0, mon_e.make});
                    check("event_ext",  {31'd0, ext},  {31'd0, mon_e.ext});
                end else begin
                    err_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        ps2Ck = 1'b1;
        ps2D  = 1'b1;
        reset = 1'b0;
        wait_clk(5);
        check_cleared("reset");
        reset = 1'b1;
        wait_clk(10);

        // Press A
        push_key(8'h1C, 1'b1, 1'b0);
        send_byte(8'h1C);
        check("code_hold", {24'd0, code}, 32'h1C);
        check("make_hold", {31'd0, make}, 32'd1);

        // Release A
        push_key(8'h1C, 1'b0, 1'b0);
        send_byte(8'hF0);
        send_byte(8'h1C);

        // Extended release of up-arrow, then bare 75
        push_key(8'h75, 1'b0, 1'b1);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        push_key(8'h75, 1'b1, 1'b0);
        send_byte(8'h75);

        // Corrupted F0 must not turn the next code into a release
        push_err();
        send_byte(8'hF0, 1'b1, 1'b0);
        push_key(8'h1C, 1'b1, 1'b0);
        send_byte(8'h1C);

        // Bad stop bit, then E1 passes through untouched
        push_err();
        send_byte(8'h33, 1'b0, 1'b1);
        push_key(8'hE1, 1'b1, 1'b0);
        send_byte(8'hE1);

        // Abandoned frame: start plus four data bits, then silence
        push_err();
        send_bits(frame(8'h2B, 1'b0, 1'b0), 5);
        ps2D = 1'b1;
        wait_clk(TOUT + 500);
        delta = err_cyc - last_fall_cyc;
        checks++;
        if (delta < TOUT + FILT || delta > TOUT + FILT + 6) begin
            errors++;
            $display("FAIL timeout_latency: got %0d clocks, required %0d..%0d", delta, TOUT + FILT, TOUT + FILT + 6);
        end
        push_key(8'h2B, 1'b1, 1'b0);
        send_byte(8'h2B);

        // Short low glitch with data low must not start a frame
        ps2D  = 1'b0;
        ps2Ck = 1'b0;
        wait_clk(10);
        ps2Ck = 1'b1;
        ps2D  = 1'b1;
        wait_clk(100);
        push_key(8'h1C, 1'b1, 1'b0);
        send_byte(8'h1C);

        // Asynchronous reset in the middle of a frame
        send_bits(frame(8'h5A, 1'b0, 1'b0), 6);
        ps2D = 1'b1;
        #2;
        reset = 1'b0;
        #2;
        check_cleared("midreset");
        wait_clk(5);
        reset = 1'b1;
        wait_clk(20);
        push_key(8'h5A, 1'b1, 1'b0);
        send_byte(8'h5A);

        wait_clk(200);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard.md
# ps2_keyboard

Receives the serial PS/2 keyboard stream and delivers decoded scan-code events (strobe, make/break, code byte) to the Spectrum core's keyboard matrix input. It is the stage directly upstream of the core's `kstb`/`make`/`code` inputs. It synchronises and de-glitches the PS/2 clock and data lines, deserialises 11-bit frames, and checks parity and stop bits. It absorbs the `E0`/`F0` prefixes so that the core sees exactly one strobe per key event.

## Interface
Parameters:
- `FILTER`, default 16: consecutive identical samples required before the filtered PS/2 clock changes level (2..64).
- `TIMEOUT`, default 56000: system clocks (1 ms at 56 MHz) without a filtered falling edge before a partial frame is abandoned (max 65535).

Ports:
- `clock`  in  1: system clock, 56 MHz; all logic on posedge.
- `reset`  in  1: asynchronous, active-low; clears all state.
- `ps2Ck`  in  1: raw PS/2 clock pin, asynchronous.
- `ps2D`  in  1: raw PS/2 data pin, asynchronous.
- `kstb`  out  1: one-clock pulse; the event on `make`/`code`/`ext` is valid.
- `make`  out  1: 1 = key press, 0 = key release (an `F0` prefix was seen).
- `code`  out  8: scan code, prefixes removed.
- `ext`  out  1: an `E0` prefix preceded this code.
- `err`  out  1: one-clock pulse on a parity error, stop-bit error or timeout.

## Operation
- **Input conditioning.** `ps2Ck` and `ps2D` each pass through a 2-flop synchroniser.
  - The synchronised clock feeds a counter-based filter. The filtered clock `fck` (reset 1) toggles only after `FILTER` consecutive samples differ from the current `fck`.
  - A filtered falling edge `fall` is one clock wide. On `fall`, the synchronised data bit is sampled.
- **Frame state machine.** States are IDLE, DATA, PARITY and STOP.
  - IDLE: a `fall` with data=0 (start bit) goes to DATA, bit counter=0. A `fall` with data=1 is ignored and the FSM stays in IDLE.
  - DATA: each `fall` shifts the data bit into `sr[7]`, right-shifting (LSB first). After the 8th bit, go to PARITY.
  - PARITY: on `fall`, capture the parity bit and go to STOP. The frame passes the parity check when XOR of the 8 data bits and the parity bit = 1 (odd parity).
  - STOP: on `fall`, if stop=1 and parity is good, the byte is accepted; otherwise pulse `err`. Either way, return to IDLE.
- **Timeout.** In any state other than IDLE, a 16-bit counter increments each clock and clears on `fall`. When it reaches `TIMEOUT`: go to IDLE, discard the byte, pulse `err`, and clear the `brk`/`ext` prefix flags. In IDLE the counter is held at 0.
- **Byte decode (accepted byte only):**
  - `F0`: set `brk`; no strobe.
  - `E0`: set the internal `extf`; no strobe.
  - Any other value:
    - pulse `kstb`;
    - set `code`=byte, `make`=!`brk` and `ext`=`extf`;
    - then clear `brk` and `extf`.
  - `E1` and all other codes are passed through unchanged.
- **Error handling.** A bad frame (parity or stop) also clears `brk` and `extf`, so that a corrupted prefix never attaches to a later code.
- **Register behaviour.** `code`, `make` and `ext` are registers. They change only in the cycle `kstb` is asserted and hold until the next event.

## Timing
- Reset values: `kstb`=0, `make`=0, `code`=8'h00, `ext`=0, `err`=0, FSM=IDLE, `fck`=1, `brk`=`extf`=0, timeout counter=0.
- **Latency.** The raw pin edge produces `fall` after 2 synchroniser clocks plus `FILTER` clocks, ±1. `kstb`/`err` assert on the clock edge immediately after the cycle in which `fall` of the stop bit is seen, and stay high for exactly 1 clock.
- **Strobe timing.** `code`/`make`/`ext` update on the same edge that raises `kstb`, so the consumer samples them with `kstb`.
- **No back-pressure.** The minimum PS/2 frame is about 660 µs, so events are always at least ~37000 clocks apart.
- **Timeout vs `fall`.** If a timeout and a `fall` coincide, the timeout wins: the FSM goes to IDLE and that `fall` is not treated as a start bit.
- **Asynchronous reset mid-frame.** All registers go to their reset values immediately. After reset is released, the next start bit begins a fresh frame.
- **Glitch rejection.** Glitches on `ps2Ck` shorter than `FILTER` clocks produce no `fall`.

## Test plan
- **Press.** Frame `1C` (A), parity 0, stop 1, at 12.5 kHz → exactly one `kstb`; `code`=1C, `make`=1, `ext`=0; `err` never asserted.
- **Break.** `F0` then `1C` → one `kstb` only, on the second byte; `code`=1C, `make`=0, `ext`=0.
- **Extended break.** `E0`, `F0`, `75` (up-arrow release) → single `kstb`; `code`=75, `make`=0, `ext`=1. A following bare `75` → `make`=1, `ext`=0.
- **Bad parity, then recovery.** Frame `F0` with a wrong parity bit → `err` pulses 1 clock, no `kstb`. A following `1C` → `make`=1, proving the flag was cleared.
- **Abandoned frame.** Start bit plus 4 data bits, then the clock held high for 60000 clocks → `err` at clock 56000 after the last `fall`, FSM=IDLE. A following full `2B` frame → `kstb`, `code`=2B.
- **Glitch and reset.** A 10-clock low glitch on `ps2Ck` in IDLE → no state change. `reset` asserted low mid-frame → all outputs 0, `code`=00. After release, `5A` decodes correctly.
